// File: rtl/gate_timer_pkg.sv
// gate_timer_pkg: shared state encoding and default width for the gate down-timer
package gate_timer_pkg;
  localparam int WIDTH_DEF = 8;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/load_down_counter.sv
// load_down_counter: loadable down-counter that saturates at zero
module load_down_counter
  import gate_timer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] value,
  output logic             zero
);
  logic [WIDTH-1:0] r_value;
  // load has priority over dec; dec at zero holds so the value never wraps
  always_ff @(posedge clk) begin
    if (reset) r_value <= '0;
    else if (load) r_value <= load_val;
    else if (dec && r_value != '0) r_value <= r_value - WIDTH'(1);
  end
  assign value = r_value;
  assign zero  = r_value == '0;
endmodule

// File: rtl/gate_down_timer.sv
// gate_down_timer: opens a gate window of load_val cycles, then pulses done; GATE_DOWN_TIMER_RELOAD_EN adds repeat_en auto-reload
module gate_down_timer
  import gate_timer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
`ifdef GATE_DOWN_TIMER_RELOAD_EN
  input  logic             repeat_en,
`endif
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             gate,
  output logic             busy,
  output logic             done
);
  state_t           r_state, w_next;
  logic             w_load, w_dec, w_zero;
  logic [WIDTH-1:0] w_load_val, w_count;
  logic             r_gate, r_busy, r_done;
`ifdef GATE_DOWN_TIMER_RELOAD_EN
  logic [WIDTH-1:0] r_period;
  // window length remembered for auto-reload
  always_ff @(posedge clk) begin
    if (reset) r_period <= '0;
    else if (r_state == IDLE && start && !abort) r_period <= load_val;
  end
`endif
  load_down_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (w_load),
    .load_val (w_load_val),
    .dec      (w_dec),
    .value    (w_count),
    .zero     (w_zero)
  );
  // next state and counter controls; abort beats start, RUN ends on the cycle count reaches 1
  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_dec      = 1'b0;
    w_load_val = load_val;
    case (r_state)
      IDLE: if (start && !abort) begin
        w_load = 1'b1;
        w_next = (load_val != '0) ? RUN : DONE;
      end
      RUN: if (abort) w_next = IDLE;
      else begin
        w_dec  = 1'b1;
        w_next = (w_zero || w_count == WIDTH'(1)) ? DONE : RUN;
      end
`ifdef GATE_DOWN_TIMER_RELOAD_EN
      DONE: if (repeat_en) begin
        w_load     = 1'b1;
        w_load_val = r_period;
        w_next     = (r_period != '0) ? RUN : DONE;
      end else w_next = IDLE;
`else
      DONE: w_next = IDLE;
`endif
      default: w_next = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  // outputs registered from the next state so they line up with the state they describe
  always_ff @(posedge clk) begin
    if (reset) begin
      r_gate <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_gate <= w_next == RUN;
      r_busy <= w_next != IDLE;
      r_done <= w_next == DONE;
    end
  end
  assign count = w_count;
  assign gate  = r_gate;
  assign busy  = r_busy;
  assign done  = r_done;
endmodule
